// File: rtl/button_debounce.sv
// Per-channel pad conditioning: synchroniser, bounce filter, and registered level/strobe/toggle outputs.
module button_debounce #(
    parameter int unsigned CHANNELS        = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 12000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [CHANNELS-1:0] i_btn,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_rise,
    output logic [CHANNELS-1:0] o_fall,
    output logic [CHANNELS-1:0] o_toggle
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q;
    logic [CHANNELS-1:0][CNT_W-1:0]       cnt_d;
    logic [CHANNELS-1:0]                  level_d;
    logic [CHANNELS-1:0]                  rise_d;
    logic [CHANNELS-1:0]                  fall_d;
    logic [CHANNELS-1:0]                  toggle_d;
    logic [CHANNELS-1:0]                  sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        cnt_d    = cnt_q;
        level_d  = o_level;
        rise_d   = '0;
        fall_d   = '0;
        toggle_d = o_toggle;
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            if (sync_s[n] == o_level[n]) begin
                cnt_d[n] = '0;
            end else if (cnt_q[n] == CNT_LAST) begin
                cnt_d[n]   = '0;
                level_d[n] = sync_s[n];
                if (sync_s[n]) begin
                    rise_d[n]   = 1'b1;
                    toggle_d[n] = ~o_toggle[n];
                end else begin
                    fall_d[n] = 1'b1;
                end
            end else begin
                cnt_d[n] = cnt_q[n] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            o_level  <= '0;
            o_rise   <= '0;
            o_fall   <= '0;
            o_toggle <= '0;
        end else begin
            sync_q[0] <= i_btn;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            cnt_q    <= cnt_d;
            o_level  <= level_d;
            o_rise   <= rise_d;
            o_fall   <= fall_d;
            o_toggle <= toggle_d;
        end
    end

endmodule
